// File: rtl/ntt_ctrl.sv
// ntt_ctrl
//   Sequencing controller for the in-place 256-point NTT (q = 8380417).
//   Each RUN cycle it issues one butterfly: a coefficient read pair
//   (j, j+len) plus the twiddle ROM index. The same addresses come back out
//   as write-back strobes PIPE_LAT cycles later. After every stage the
//   controller drains for PIPE_LAT cycles, so the writes of one stage land
//   before the next stage starts reading.
//
// Optional feature, macro INTT_EN:
//   Adds the input `inv`, sampled together with start, and the registered
//   output `mode_inv`. With inv=1 the controller runs the inverse schedule:
//   len ascends from 1 and zeta_idx counts down from N-1.
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous active-low reset
//   start     in   begin a transform (sampled in IDLE only)
//   inv       in   inverse-schedule select             (INTT_EN only)
//   mode_inv  out  inverse mode of current transform   (INTT_EN only)
//   busy      out  high from the cycle after start until done
//   done      out  one-cycle completion pulse
//   rd_en     out  coefficient pair read request
//   rd_addr0  out  index j
//   rd_addr1  out  index j+len
//   zeta_idx  out  twiddle ROM index, valid with rd_en
//   wr_en     out  write-back strobe (rd_en delayed PIPE_LAT)
//   wr_addr0  out  out0 destination (rd_addr0 delayed PIPE_LAT)
//   wr_addr1  out  out1 destination (rd_addr1 delayed PIPE_LAT)
module ntt_ctrl #(
    parameter int unsigned N        = 256,
    parameter int unsigned LOG_N    = 8,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned PIPE_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
`ifdef INTT_EN
    input  logic              inv,
    output logic              mode_inv,
`endif
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr0,
    output logic [ADDR_W-1:0] rd_addr1,
    output logic [ADDR_W-1:0] zeta_idx,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr0,
    output logic [ADDR_W-1:0] wr_addr1
);

    localparam int unsigned SW = $clog2(LOG_N);
    localparam int unsigned IW = LOG_N - 1;
    localparam int unsigned PW = 2 * ADDR_W + 1;

    localparam logic [SW-1:0]     LAST_STAGE = SW'(LOG_N - 1);
    localparam logic [SW-1:0]     STAGE_ONE  = SW'(1);
    localparam logic [IW-1:0]     IDX_LAST   = IW'(N / 2 - 1);
    localparam logic [IW-1:0]     IDX_ONE    = IW'(1);
    localparam logic [2:0]        DRAIN_LAST = 3'(PIPE_LAT - 1);
    localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t            state, nxt_state;
    logic [SW-1:0]     stage, nxt_stage;
    logic [IW-1:0]     idx, nxt_idx;
    logic [2:0]        drain_cnt, nxt_drain;
    logic              inv_q, nxt_inv;
    logic              inv_in;

    logic              nxt_rd_en, nxt_busy, nxt_done;
    logic [ADDR_W-1:0] nxt_a0, nxt_a1, nxt_zeta;

    logic [SW-1:0]     fwd_ll, log_len;
    logic [ADDR_W-1:0] i_ext, blk, len, zeta_fwd, zeta_inv;

    logic [PW-1:0]     dline [PIPE_LAT];

`ifdef INTT_EN
    assign inv_in   = inv;
    assign mode_inv = inv_q;
`else
    assign inv_in   = 1'b0;
`endif

    // Next state, next counters and the next registered outputs. The issue
    // address is derived in closed form from (stage, issue index):
    //   block = idx >> log2(len), j = block*2*len + (idx mod len).
    // Forward zeta for that block is 2^stage + block; inverse zeta is
    // 2^(LOG_N-stage) - 1 - block. This matches the running k counter of
    // the textbook loop without needing to carry k between stages.
    always_comb begin
        nxt_state = state;
        nxt_stage = stage;
        nxt_idx   = idx;
        nxt_drain = drain_cnt;
        nxt_inv   = inv_q;
        nxt_rd_en = 1'b0;
        nxt_busy  = 1'b0;
        nxt_done  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    nxt_state = ST_RUN;
                    nxt_stage = '0;
                    nxt_idx   = '0;
                    nxt_inv   = inv_in;
                    nxt_rd_en = 1'b1;
                    nxt_busy  = 1'b1;
                end
            end
            ST_RUN: begin
                nxt_busy = 1'b1;
                if (idx == IDX_LAST) begin
                    nxt_state = ST_DRAIN;
                    nxt_drain = '0;
                end else begin
                    nxt_idx   = idx + IDX_ONE;
                    nxt_rd_en = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    if (stage == LAST_STAGE) begin
                        nxt_state = ST_DONE;
                        nxt_done  = 1'b1;
                    end else begin
                        nxt_state = ST_RUN;
                        nxt_stage = stage + STAGE_ONE;
                        nxt_idx   = '0;
                        nxt_rd_en = 1'b1;
                        nxt_busy  = 1'b1;
                    end
                end else begin
                    nxt_drain = drain_cnt + 3'd1;
                    nxt_busy  = 1'b1;
                end
            end
            ST_DONE: begin
                nxt_state = ST_IDLE;
            end
            default: begin
                nxt_state = ST_IDLE;
            end
        endcase

        fwd_ll   = LAST_STAGE - nxt_stage;
        log_len  = nxt_inv ? nxt_stage : fwd_ll;
        i_ext    = ADDR_W'(nxt_idx);
        blk      = i_ext >> log_len;
        len      = ONE << log_len;
        zeta_fwd = (ONE << nxt_stage) + blk;
        zeta_inv = ((ONE << fwd_ll) << 1) - ONE - blk;

        nxt_a0   = '0;
        nxt_a1   = '0;
        nxt_zeta = '0;
        if (nxt_rd_en) begin
            nxt_a0   = ((blk << log_len) << 1) | (i_ext & (len - ONE));
            nxt_a1   = nxt_a0 + len;
            nxt_zeta = nxt_inv ? zeta_inv : zeta_fwd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            stage     <= '0;
            idx       <= '0;
            drain_cnt <= '0;
            inv_q     <= 1'b0;
            rd_en     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_addr0  <= '0;
            rd_addr1  <= '0;
            zeta_idx  <= '0;
        end else begin
            state     <= nxt_state;
            stage     <= nxt_stage;
            idx       <= nxt_idx;
            drain_cnt <= nxt_drain;
            inv_q     <= nxt_inv;
            rd_en     <= nxt_rd_en;
            busy      <= nxt_busy;
            done      <= nxt_done;
            rd_addr0  <= nxt_a0;
            rd_addr1  <= nxt_a1;
            zeta_idx  <= nxt_zeta;
        end
    end

    // Write-back delay line fed from the registered read outputs. The tail
    // is a register, so the wr_* outputs stay registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < PIPE_LAT; i++) begin
                dline[i] <= '0;
            end
        end else begin
            dline[0] <= {rd_en, rd_addr0, rd_addr1};
            for (int unsigned i = 1; i < PIPE_LAT; i++) begin
                dline[i] <= dline[i-1];
            end
        end
    end

    assign {wr_en, wr_addr0, wr_addr1} = dline[PIPE_LAT-1];

endmodule

// File: tb/tb_ntt_ctrl.sv
// tb_ntt_ctrl
//   Two controllers, PIPE_LAT=2 and PIPE_LAT=4, share one stimulus. A model
//   writes out each transform's expected per-cycle issue timeline straight
//   from the nested len/block/j loops. A single compare process checks both
//   DUTs against that timeline on every falling edge. Cycle 0 is the cycle
//   in which start is sampled.
module tb_ntt_ctrl;

    localparam int TL = 1200;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic inv = 1'b0;

    logic [1:0] rd_en_w, wr_en_w, busy_w, done_w;
    logic [7:0] ra0 [2];
    logic [7:0] ra1 [2];
    logic [7:0] zt  [2];
    logic [7:0] wa0 [2];
    logic [7:0] wa1 [2];
`ifdef INTT_EN
    logic [1:0] minv_w;
`endif

    always #5 clk = ~clk;

    ntt_ctrl #(.N(256), .LOG_N(8), .ADDR_W(8), .PIPE_LAT(2)) u_lat2 (
        .clk(clk), .reset(reset), .start(start),
`ifdef INTT_EN
        .inv(inv), .mode_inv(minv_w[0]),
`endif
        .busy(busy_w[0]), .done(done_w[0]), .rd_en(rd_en_w[0]),
        .rd_addr0(ra0[0]), .rd_addr1(ra1[0]), .zeta_idx(zt[0]),
        .wr_en(wr_en_w[0]), .wr_addr0(wa0[0]), .wr_addr1(wa1[0])
    );

    ntt_ctrl #(.N(256), .LOG_N(8), .ADDR_W(8), .PIPE_LAT(4)) u_lat4 (
        .clk(clk), .reset(reset), .start(start),
`ifdef INTT_EN
        .inv(inv), .mode_inv(minv_w[1]),
`endif
        .busy(busy_w[1]), .done(done_w[1]), .rd_en(rd_en_w[1]),
        .rd_addr0(ra0[1]), .rd_addr1(ra1[1]), .zeta_idx(zt[1]),
        .wr_en(wr_en_w[1]), .wr_addr0(wa0[1]), .wr_addr1(wa1[1])
    );

    // Model state
    logic       tl_en [2][TL];
    logic [7:0] tl_a0 [2][TL];
    logic [7:0] tl_a1 [2][TL];
    logic [7:0] tl_z  [2][TL];
    int lat_m [2] = '{2, 4};
    int done_c [2];
    int t [2];
    bit run_m [2];
    bit inv_m [2];
    int cnt_rd [2];
    int cnt_wr [2];

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input int m, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s dut%0d t=%0d got=%h expected=%h", nm, m, t[m], a, e);
        end
    endtask

    // Expected timeline straight from the Dilithium loop nest.
    task automatic build(input int m, input bit iv);
        int c, k, len;
        for (int x = 0; x < TL; x++) begin
            tl_en[m][x] = 1'b0;
            tl_a0[m][x] = '0;
            tl_a1[m][x] = '0;
            tl_z[m][x]  = '0;
        end
        c = 1;
        k = iv ? 256 : 0;
        for (int s = 0; s < 8; s++) begin
            len = iv ? (1 << s) : (128 >> s);
            for (int st = 0; st < 256; st += 2 * len) begin
                k = iv ? k - 1 : k + 1;
                for (int j = st; j < st + len; j++) begin
                    tl_en[m][c] = 1'b1;
                    tl_a0[m][c] = 8'(j);
                    tl_a1[m][c] = 8'(j + len);
                    tl_z[m][c]  = 8'(k);
                    c++;
                end
            end
            c += lat_m[m];
        end
        done_c[m] = c;
    endtask

    // Model sequencing: start is accepted only while the model is idle.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_m[0] = 1'b0;
            run_m[1] = 1'b0;
        end else begin
            for (int m = 0; m < 2; m++) begin
                if ((!run_m[m] || t[m] > done_c[m]) && start) begin
                    build(m, inv);
                    run_m[m]  = 1'b1;
                    inv_m[m]  = inv;
                    t[m]      = 1;
                    cnt_rd[m] = 0;
                    cnt_wr[m] = 0;
                end else if (run_m[m] && t[m] < 100000) begin
                    t[m]++;
                end
            end
        end
    end

    // Compare process
    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (!reset) begin
                chk("reset_outputs", m,
                    {rd_en_w[m], wr_en_w[m], busy_w[m], done_w[m],
                     ra0[m], ra1[m], zt[m], wa0[m], wa1[m]}, '0);
            end else begin
                bit act, e_rd, e_wr, e_busy, e_done;
                int tt;
                tt = t[m];
                act = run_m[m] && tt <= done_c[m];
                e_rd = 1'b0;
                e_wr = 1'b0;
                e_busy = 1'b0;
                e_done = 1'b0;
                if (act) begin
                    e_rd   = tl_en[m][tt];
                    e_wr   = (tt >= lat_m[m]) && tl_en[m][tt - lat_m[m]];
                    e_busy = (tt >= 1) && (tt < done_c[m]);
                    e_done = (tt == done_c[m]);
                end
                if (rd_en_w[m] === 1'b1) cnt_rd[m]++;
                if (wr_en_w[m] === 1'b1) cnt_wr[m]++;
                chk("ctl_rd_wr_busy_done", m,
                    {rd_en_w[m], wr_en_w[m], busy_w[m], done_w[m]},
                    {e_rd, e_wr, e_busy, e_done});
                if (e_rd)
                    chk("rd_addr_zeta", m, {ra0[m], ra1[m], zt[m]},
                        {tl_a0[m][tt], tl_a1[m][tt], tl_z[m][tt]});
                if (e_wr)
                    chk("wr_addr", m, {wa0[m], wa1[m]},
                        {tl_a0[m][tt - lat_m[m]], tl_a1[m][tt - lat_m[m]]});
                if (e_done) begin
                    chk("rd_count", m, 64'(cnt_rd[m]), 64'd1024);
                    chk("wr_count", m, 64'(cnt_wr[m]), 64'd1024);
                end
`ifdef INTT_EN
                if (e_busy)
                    chk("mode_inv", m, 64'(minv_w[m]), 64'(inv_m[m]));
`endif
            end
        end
    end

    task automatic pulse_start(input bit iv);
        #1 start = 1'b1;
        inv = iv;
        @(posedge clk);
        #1 start = 1'b0;
        inv = 1'b0;
    endtask

    initial begin
        // Reset held for 3 cycles
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);

        // Single forward run; pin the model against hand-derived points
        pulse_start(1'b0);
        chk("pin_first_issue", 0, {tl_en[0][1], tl_a0[0][1], tl_a1[0][1], tl_z[0][1]},
            {1'b1, 8'd0, 8'd128, 8'd1});
        chk("pin_issue128", 0, {tl_en[0][128], tl_a0[0][128], tl_a1[0][128], tl_z[0][128]},
            {1'b1, 8'd127, 8'd255, 8'd1});
        chk("pin_drain", 0, 64'(tl_en[0][129]), 64'd0);
        chk("pin_stage2_first", 0, {tl_en[0][131], tl_a0[0][131], tl_a1[0][131], tl_z[0][131]},
            {1'b1, 8'd0, 8'd64, 8'd2});
        chk("pin_stage2_j128", 0, {tl_en[0][195], tl_a0[0][195], tl_a1[0][195], tl_z[0][195]},
            {1'b1, 8'd128, 8'd192, 8'd3});
        chk("pin_last_issue", 0, {tl_en[0][1038], tl_a0[0][1038], tl_a1[0][1038], tl_z[0][1038]},
            {1'b1, 8'd254, 8'd255, 8'd255});
        chk("pin_done_lat2", 0, 64'(done_c[0]), 64'd1041);
        chk("pin_done_lat4", 1, 64'(done_c[1]), 64'd1057);
        repeat (1080) @(posedge clk);

        // start held high through the whole run, including the done cycle
        #1 start = 1'b1;
        repeat (1042) @(posedge clk);
        #1 start = 1'b0;
        repeat (40) @(posedge clk);

        // Second run must be identical
        pulse_start(1'b0);
        repeat (1080) @(posedge clk);

        // Reset in the middle of stage 3 aborts immediately
        pulse_start(1'b0);
        repeat (300) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("abort_rd_en", 0, 64'(rd_en_w), 64'd0);
        chk("abort_wr_en", 0, 64'(wr_en_w), 64'd0);
        chk("abort_busy", 0, 64'(busy_w), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        pulse_start(1'b0);
        repeat (1080) @(posedge clk);

`ifdef INTT_EN
        // Inverse schedule
        pulse_start(1'b1);
        chk("pin_inv_first", 0, {tl_en[0][1], tl_a0[0][1], tl_a1[0][1], tl_z[0][1]},
            {1'b1, 8'd0, 8'd1, 8'd255});
        chk("pin_inv_last", 0, {tl_en[0][1038], tl_a0[0][1038], tl_a1[0][1038], tl_z[0][1038]},
            {1'b1, 8'd127, 8'd255, 8'd1});
        repeat (1080) @(posedge clk);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
